// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Optional status flags are enabled with the ALU_SEQ_FLAGS_EN macro.
package alu_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit positions inside the slice control word {ex,nx,ey,ny,f,no}
    localparam int CB_EX = 5;
    localparam int CB_NX = 4;
    localparam int CB_EY = 3;
    localparam int CB_NY = 2;
    localparam int CB_F  = 1;
    localparam int CB_NO = 0;

    // Common control words; X+1 is ADD with y disabled and carry-in set
    localparam logic [5:0] OPC_ADD = 6'h2A;
    localparam logic [5:0] OPC_AND = 6'h28;

    // Width of the nibble counter; at least one bit even for a single nibble
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_nibble_seq_accum.sv
// nibble_accum: assembles the W-bit result one nibble at a time.
// With ALU_SEQ_FLAGS_EN it also produces zero/neg flags using a running
// all-nibbles-zero bit instead of a full-width compare.
module nibble_accum
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W  = 4 * NIBBLES,
    localparam int KW = cnt_width(NIBBLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [KW-1:0] k,
    input  logic [3:0]    nib,
`ifdef ALU_SEQ_FLAGS_EN
    input  logic          last,
    output logic          zero,
    output logic          neg,
`endif
    output logic [W-1:0]  result
);

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            logic [3:0] nib_q;
            logic [3:0] nib_d;

            // Capture the slice output into this nibble when it is the one in flight
            always_comb begin
                nib_d = nib_q;
                if (we && (k == KW'(gi))) begin
                    nib_d = nib;
                end
            end

            // Nibble storage; cleared on reset so an aborted operation leaves 0
            always_ff @(posedge clk) begin
                if (reset) begin
                    nib_q <= 4'h0;
                end else begin
                    nib_q <= nib_d;
                end
            end

            assign result[gi*4 +: 4] = nib_q;
        end
    endgenerate

`ifdef ALU_SEQ_FLAGS_EN
    logic allz_q, allz_d;
    logic zero_q, zero_d;
    logic neg_q,  neg_d;
    logic run_zero;

    // Running zero tracker restarts at nibble 0; flags commit with the final nibble
    always_comb begin
        allz_d   = allz_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        run_zero = ((k == '0) ? 1'b1 : allz_q) & (nib == 4'h0);
        if (we) begin
            allz_d = run_zero;
            if (last) begin
                zero_d = run_zero;
                neg_d  = nib[3];
            end
        end
    end

    // Flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            allz_q <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            allz_q <= allz_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
`endif

endmodule

// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: runs a W-bit ALU operation through one external 4-bit
// slice, LSB nibble first, chaining the slice carry between nibbles.
// Define ALU_SEQ_FLAGS_EN to add registered zero/neg result flags.
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W  = 4 * NIBBLES,
    localparam int KW = cnt_width(NIBBLES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] op_x,
    input  logic [W-1:0] op_y,
    input  logic [5:0]   op_c,
    input  logic         op_cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
`ifdef ALU_SEQ_FLAGS_EN
    output logic         zero,
    output logic         neg,
`endif
    output logic [3:0]   slice_x,
    output logic [3:0]   slice_y,
    output logic [5:0]   slice_c,
    output logic         slice_cin,
    input  logic [3:0]   slice_out,
    input  logic         slice_cout
);

    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_q,     k_d;
    logic [W-1:0]  x_q,     x_d;
    logic [W-1:0]  y_q,     y_d;
    logic [5:0]    c_q,     c_d;
    logic          cin_q,   cin_d;
    logic          carry_q, carry_d;
    logic          cout_q,  cout_d;

    logic          acc_we;
    logic          acc_last;

    // State, counter, latched operands and carry registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= 6'h00;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state: accept start in IDLE or DONE, step nibbles in RUN
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        cin_d   = cin_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_RUN: begin
                carry_d = slice_cout;
                if (k_q == K_LAST) begin
                    cout_d  = slice_cout;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE behave alike: DONE allows a back-to-back start
                if (start) begin
                    x_d     = op_x;
                    y_d     = op_y;
                    c_d     = op_c;
                    cin_d   = op_cin;
                    k_d     = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Outputs: status, slice operand muxing and accumulator write control
    always_comb begin
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        slice_x   = x_q[k_q*4 +: 4];
        slice_y   = y_q[k_q*4 +: 4];
        slice_c   = c_q;
        slice_cin = (k_q == '0) ? cin_q : carry_q;
        acc_we    = (state_q == ST_RUN);
        acc_last  = (k_q == K_LAST);
    end

    nibble_accum #(
        .NIBBLES (NIBBLES)
    ) u_accum (
        .clk    (clk),
        .reset  (reset),
        .we     (acc_we),
        .k      (k_q),
        .nib    (slice_out),
`ifdef ALU_SEQ_FLAGS_EN
        .last   (acc_last),
        .zero   (zero),
        .neg    (neg),
`endif
        .result (result)
    );

`ifndef ALU_SEQ_FLAGS_EN
    // Only the flag tracker consumes the last-nibble indication
    logic unused_last;
    assign unused_last = acc_last;
`endif

    assign cout = cout_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Testbench for alu_nibble_seq with a behavioural 4-bit slice attached.
// Set ALU_SEQ_FLAGS_EN to also check the zero/neg flags.
module tb_alu_nibble_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_x, op_y;
    logic [5:0]   op_c;
    logic         op_cin;
    logic         busy, done, cout;
    logic [W-1:0] result;
`ifdef ALU_SEQ_FLAGS_EN
    logic         zero, neg;
`endif
    logic [3:0]   slice_x, slice_y, slice_out;
    logic [5:0]   slice_c;
    logic         slice_cin, slice_cout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_nibble_seq #(.NIBBLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_x       (op_x),
        .op_y       (op_y),
        .op_c       (op_c),
        .op_cin     (op_cin),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
`ifdef ALU_SEQ_FLAGS_EN
        .zero       (zero),
        .neg        (neg),
`endif
        .slice_x    (slice_x),
        .slice_y    (slice_y),
        .slice_c    (slice_c),
        .slice_cin  (slice_cin),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    // The 4-bit slice: enable/negate each input, add or AND, optionally negate
    logic [3:0] s_x, s_y;
    logic [4:0] s_sum;
    always_comb begin
        s_x        = slice_c[5] ? slice_x : 4'h0;
        if (slice_c[4]) s_x = ~s_x;
        s_y        = slice_c[3] ? slice_y : 4'h0;
        if (slice_c[2]) s_y = ~s_y;
        s_sum      = {1'b0, s_x} + {1'b0, s_y} + {4'h0, slice_cin};
        slice_out  = slice_c[1] ? s_sum[3:0] : (s_x & s_y);
        slice_cout = slice_c[1] ? s_sum[4] : 1'b0;
        if (slice_c[0]) slice_out = ~slice_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full-width reference operands after enable/negate
    function automatic logic [W-1:0] prep(input logic [W-1:0] v, input logic en, input logic inv);
        logic [W-1:0] r;
        r = en ? v : '0;
        return inv ? ~r : r;
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [5:0] c, input logic cin);
        op_x = x; op_y = y; op_c = c; op_cin = cin; start = 1'b1;
    endtask

    // Follows an operation whose start is already driven; optional stray start
    // at RUN cycle inject_at, optional reset at RUN cycle abort_at (0 = none).
    task automatic follow_op(input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [5:0] c, input logic cin,
                             input int inject_at, input int abort_at, input string tag);
        logic [W-1:0] xv, yv, exp_r;
        logic [W:0]   full;
        logic [31:0]  lo, exp_cin;
        logic         exp_co;
        xv    = prep(x, c[5], c[4]);
        yv    = prep(y, c[3], c[2]);
        full  = {1'b0, xv} + {1'b0, yv} + {{W{1'b0}}, cin};
        exp_r = c[1] ? full[W-1:0] : (xv & yv);
        if (c[0]) exp_r = ~exp_r;
        exp_co = c[1] ? full[W] : 1'b0;
        for (int j = 1; j <= N + 1; j++) begin
            @(negedge clk);
            if (j <= N) begin
                lo = 32'(((64'(xv) & ((64'd1 << (4*(j-1))) - 1)) +
                          (64'(yv) & ((64'd1 << (4*(j-1))) - 1)) + 64'(cin)) >> (4*(j-1)));
                exp_cin = (j == 1) ? 32'(cin) : (c[1] ? (lo & 32'd1) : 32'd0);
                chk({tag, "_busy"},  32'(busy), 32'd1);
                chk({tag, "_done0"}, 32'(done), 32'd0);
                chk({tag, "_sx"},    32'(slice_x), 32'(x[4*(j-1) +: 4]));
                chk({tag, "_sy"},    32'(slice_y), 32'(y[4*(j-1) +: 4]));
                chk({tag, "_sc"},    32'(slice_c), 32'(c));
                chk({tag, "_scin"},  32'(slice_cin), exp_cin);
            end else begin
                chk({tag, "_done"},   32'(done), 32'd1);
                chk({tag, "_idle"},   32'(busy), 32'd0);
                chk({tag, "_result"}, 32'(result), 32'(exp_r));
                chk({tag, "_cout"},   32'(cout), 32'(exp_co));
`ifdef ALU_SEQ_FLAGS_EN
                chk({tag, "_zero"},   32'(zero), 32'(exp_r == '0));
                chk({tag, "_neg"},    32'(neg),  32'(exp_r[W-1]));
`endif
                $display("op %s x=%h y=%h c=%h cin=%0d -> result=%h cout=%0d (exp %h/%0d)",
                         tag, x, y, c, cin, result, cout, exp_r, exp_co);
            end
            if (j == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk({tag, "_abort_busy"},   32'(busy), 32'd0);
                chk({tag, "_abort_done"},   32'(done), 32'd0);
                chk({tag, "_abort_result"}, 32'(result), 32'd0);
                chk({tag, "_abort_cout"},   32'(cout), 32'd0);
                chk({tag, "_abort_sc"},     32'(slice_c), 32'd0);
                reset = 1'b0;
                for (int m = 0; m < 6; m++) begin
                    @(negedge clk);
                    chk({tag, "_abort_nodone"}, 32'(done), 32'd0);
                end
                $display("op %s aborted by reset at RUN cycle %0d", tag, j);
                return;
            end
            start = (j == inject_at);
            if (j == inject_at) op_x = '0;
        end
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        logic [5:0]   rc;
        logic         rcin;

        reset = 1'b1; start = 1'b0;
        op_x = '0; op_y = '0; op_c = '0; op_cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout",   32'(cout), 32'd0);
        chk("rst_sx",     32'(slice_x), 32'd0);
        chk("rst_sy",     32'(slice_y), 32'd0);
        chk("rst_sc",     32'(slice_c), 32'd0);
        chk("rst_scin",   32'(slice_cin), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("rst_zero",   32'(zero), 32'd0);
        chk("rst_neg",    32'(neg),  32'd0);
`endif
        $display("reset state checked");
        reset = 1'b0;
        @(negedge clk);

        // Directed: ADD with carries rippling through the middle nibbles
        launch(16'h1234, 16'h0FFF, 6'h2A, 1'b0);
        follow_op(16'h1234, 16'h0FFF, 6'h2A, 1'b0, 0, 0, "t1");
        chk("t1_result_const", 32'(result), 32'h2233);
        @(negedge clk);
        chk("t1_done_once", 32'(done), 32'd0);
        chk("t1_hold",      32'(result), 32'h2233);

        // Directed: ADD wrapping to zero with carry out
        launch(16'hFFFF, 16'h0001, 6'h2A, 1'b0);
        follow_op(16'hFFFF, 16'h0001, 6'h2A, 1'b0, 0, 0, "t2");
        chk("t2_result_const", 32'(result), 32'h0000);
        chk("t2_cout_const",   32'(cout), 32'd1);
`ifdef ALU_SEQ_FLAGS_EN
        chk("t2_zero_const",   32'(zero), 32'd1);
        chk("t2_neg_const",    32'(neg),  32'd0);
`endif
        @(negedge clk);

        // Directed: AND
        launch(16'hF0F0, 16'h3C3C, 6'h28, 1'b0);
        follow_op(16'hF0F0, 16'h3C3C, 6'h28, 1'b0, 0, 0, "t3");
        chk("t3_result_const", 32'(result), 32'h3030);
        @(negedge clk);

        // Start during RUN is ignored; start held in DONE chains the next op
        launch(16'h1234, 16'h0FFF, 6'h2A, 1'b0);
        follow_op(16'h1234, 16'h0FFF, 6'h2A, 1'b0, 2, 0, "t4a");
        chk("t4a_result_const", 32'(result), 32'h2233);
        launch(16'hFFFF, 16'h0001, 6'h2A, 1'b0);
        follow_op(16'hFFFF, 16'h0001, 6'h2A, 1'b0, 0, 0, "t4b");
        chk("t4b_result_const", 32'(result), 32'h0000);

        // Reset mid-RUN aborts without a done pulse
        launch(16'hFFFF, 16'h0001, 6'h2A, 1'b0);
        follow_op(16'hFFFF, 16'h0001, 6'h2A, 1'b0, 0, 3, "t5");

        // Random control words and operands, mixing idle gaps and back-to-back
        for (int i = 0; i < 24; i++) begin
            rx   = W'($urandom);
            ry   = W'($urandom);
            rc   = 6'($urandom_range(0, 63));
            rcin = 1'($urandom_range(0, 1));
            launch(rx, ry, rc, rcin);
            follow_op(rx, ry, rc, rcin, 0, 0, $sformatf("r%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk("rand_gap_done", 32'(done), 32'd0);
            end
        end
        @(negedge clk);

        // Reset wins over start in the same cycle
        reset = 1'b1;
        launch(16'h1111, 16'h2222, 6'h2A, 1'b0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_dom_busy", 32'(busy), 32'd0);
        chk("rst_dom_done", 32'(done), 32'd0);
        $display("reset-vs-start checked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
